// File: rtl/cmp_share_arb_if.sv
// Request/response bundle between the compare clients and the shared
// comparator sequencer. The master side drives requests and operands, the
// slave side returns acknowledge, grant index and comparison results.
interface cmp_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 5
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gray_in;
  logic [NREQ-1:0]   ack;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              aeqb;
  logic              agtb;
  logic              altb;

  modport master (
    output req, a_in, b_in, gray_in,
    input  ack, grant_id, busy, aeqb, agtb, altb
  );

  modport slave (
    input  req, a_in, b_in, gray_in,
    output ack, grant_id, busy, aeqb, agtb, altb
  );
endinterface

// File: rtl/cmp_share_arb.sv
// Round-robin sequencer sharing one unsigned magnitude comparator among
// NREQ requesters. A grant latches the winner's operands (Gray-decoded when
// flagged), the next cycle registers the compare result and pulses ack, and
// a third cycle returns to IDLE, giving one comparison per three cycles.
module cmp_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  cmp_share_arb_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t          state_reg;
  logic [IW-1:0]   last_reg;
  logic [IW-1:0]   grant_reg;
  logic [NREQ-1:0] ack_reg;
  logic            busy_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            aeqb_reg;
  logic            agtb_reg;
  logic            altb_reg;

  logic [W-1:0]    a_bin [NREQ];
  logic [W-1:0]    b_bin [NREQ];
  logic [IW-1:0]   winner;
  logic            found;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Per-requester operand decode, so the grant only has to select one lane.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_decode
      assign a_bin[gi] = bus.gray_in[gi] ? gray2bin(bus.a_in[gi*W +: W]) : bus.a_in[gi*W +: W];
      assign b_bin[gi] = bus.gray_in[gi] ? gray2bin(bus.b_in[gi*W +: W]) : bus.b_in[gi*W +: W];
    end
  endgenerate

  // Round-robin search starting just after the last served requester.
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int o = 1; o <= NREQ; o++) begin
      idx  = (int'(last_reg) + o) % NREQ;
      cand = IW'(idx);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Grant / evaluate / hold sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= IW'(NREQ - 1);
      grant_reg <= '0;
      ack_reg   <= '0;
      busy_reg  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      aeqb_reg  <= 1'b0;
      agtb_reg  <= 1'b0;
      altb_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            grant_reg <= winner;
            a_reg     <= a_bin[winner];
            b_reg     <= b_bin[winner];
            busy_reg  <= 1'b1;
            state_reg <= EVAL;
          end
        end
        EVAL: begin
          aeqb_reg           <= (a_reg == b_reg);
          agtb_reg           <= (a_reg >  b_reg);
          altb_reg           <= (a_reg <  b_reg);
          ack_reg            <= '0;
          ack_reg[grant_reg] <= 1'b1;
          last_reg           <= grant_reg;
          state_reg          <= HOLD;
        end
        HOLD: begin
          ack_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          ack_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = ack_reg;
  assign bus.grant_id = grant_reg;
  assign bus.busy     = busy_reg;
  assign bus.aeqb     = aeqb_reg;
  assign bus.agtb     = agtb_reg;
  assign bus.altb     = altb_reg;
endmodule

// File: tb/tb_cmp_share_arb.sv
// Randomized and directed bench for cmp_share_arb against a behavioural
// round-robin / compare model.
module tb_cmp_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 5;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cmp_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();

  cmp_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int last_m;
  int a_v [NREQ];
  int b_v [NREQ];
  bit g_v [NREQ];
  logic [NREQ-1:0] req_v;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Gray decode as a running XOR of right shifts.
  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < W; s++) b ^= (g >> s);
    return b & MASK;
  endfunction

  function automatic int exp_winner(input int mask);
    for (int o = 1; o <= NREQ; o++) begin
      int idx = (last_m + o) % NREQ;
      if (((mask >> idx) & 1) == 1) return idx;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.a_in[i*W +: W]  = W'(a_v[i]);
      bus.b_in[i*W +: W]  = W'(b_v[i]);
      bus.gray_in[i]      = g_v[i];
    end
    bus.req = req_v;
  endtask

  task automatic set_op(input int i, input int a, input int b, input bit g);
    a_v[i] = a; b_v[i] = b; g_v[i] = g;
    drive();
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = int'($urandom_range(0, MASK));
      b_v[i] = ($urandom_range(0, 3) == 0) ? a_v[i] : int'($urandom_range(0, MASK));
      g_v[i] = 1'($urandom_range(0, 1));
    end
    drive();
  endtask

  // One transaction from an IDLE negedge: expects the model's winner acked
  // two edges later with the model's compare result, then IDLE again.
  task automatic serve(input bit scramble, input bit keep);
    int  w, ea, eb, cyc;
    bit  seen;
    w = exp_winner(int'(req_v));
    if (w < 0) begin
      check("no_request", 0, 1);
      return;
    end
    ea = g_v[w] ? g2b(a_v[w]) : a_v[w];
    eb = g_v[w] ? g2b(b_v[w]) : b_v[w];
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("busy_eval", int'(bus.busy), 1);
        check("ack_early", int'(bus.ack), 0);
        if (scramble) rand_ops();
      end
      if (bus.ack != '0) seen = 1'b1;
    end
    if (!seen) begin
      check("ack_timeout", 0, 1);
      return;
    end
    check("latency", cyc, 2);
    check("ack_onehot", int'(bus.ack), 1 << w);
    check("grant_id", int'(bus.grant_id), w);
    check("busy_ack", int'(bus.busy), 1);
    check("aeqb", int'(bus.aeqb), int'(ea == eb));
    check("agtb", int'(bus.agtb), int'(ea > eb));
    check("altb", int'(bus.altb), int'(ea < eb));
    $display("txn req=%0d a=%0d b=%0d -> eq=%0d gt=%0d lt=%0d", w, ea, eb,
             bus.aeqb, bus.agtb, bus.altb);
    last_m = w;
    if (!keep) req_v[w] = 1'b0;
    bus.req = req_v;
    @(negedge clk);
    check("ack_clear", int'(bus.ack), 0);
    check("busy_clear", int'(bus.busy), 0);
    check("result_hold", int'({bus.aeqb, bus.agtb, bus.altb}),
          int'({ea == eb, ea > eb, ea < eb}));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_m = NREQ - 1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = 0; b_v[i] = 0; g_v[i] = 1'b0;
    end
    drive();
    repeat (2) @(negedge clk);
    check("rst_ack", int'(bus.ack), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_grant", int'(bus.grant_id), 0);
    check("rst_result", int'({bus.aeqb, bus.agtb, bus.altb}), 0);
    rst_n = 1'b1;
    last_m = NREQ - 1;
    @(negedge clk);

    // Basic binary compare on requester 0.
    set_op(0, 9, 5, 1'b0); req_v = 4'b0001; drive();
    serve(1'b0, 1'b0);
    check("t1_agtb", int'(bus.agtb), 1);

    // Gray-coded operands on requester 2.
    set_op(2, 5'b01101, 5'b01101, 1'b1); req_v = 4'b0100; drive();
    serve(1'b0, 1'b0);
    check("gray_eq", int'(bus.aeqb), 1);
    set_op(2, 5'b01101, 5'b01100, 1'b1); req_v = 4'b0100; drive();
    serve(1'b0, 1'b0);
    check("gray_gt", int'(bus.agtb), 1);

    // Extreme operand values.
    set_op(3, 0, 31, 1'b0); req_v = 4'b1000; drive(); serve(1'b0, 1'b0);
    check("bnd_lt", int'(bus.altb), 1);
    set_op(3, 31, 0, 1'b0); req_v = 4'b1000; drive(); serve(1'b0, 1'b0);
    check("bnd_gt", int'(bus.agtb), 1);
    set_op(3, 0, 0, 1'b0); req_v = 4'b1000; drive(); serve(1'b0, 1'b0);
    check("bnd_eq", int'(bus.aeqb), 1);

    // Fairness: all held from reset, then again, then 3 before 1.
    rand_ops();
    req_v = 4'b1111; drive();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      serve(1'b0, 1'b0);
      check("order_a", last_m, i);
    end
    req_v = 4'b1111; drive();
    for (int i = 0; i < NREQ; i++) begin
      serve(1'b0, 1'b0);
      check("order_b", last_m, i);
    end
    req_v = 4'b0010; drive(); serve(1'b0, 1'b0);
    req_v = 4'b1010; drive();
    serve(1'b0, 1'b0); check("order_31_first", last_m, 3);
    serve(1'b0, 1'b0); check("order_31_second", last_m, 1);

    // Drop at ack: no second ack.
    req_v = 4'b0010; drive(); serve(1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      check("no_second_ack", int'(bus.ack), 0);
    end
    // Held through HOLD: re-granted at k+3 (serve checks latency).
    req_v = 4'b0010; drive();
    serve(1'b0, 1'b1);
    serve(1'b1, 1'b0);

    // Reset during EVAL, request held through reset.
    set_op(0, 20, 7, 1'b0); req_v = 4'b0001; drive();
    @(negedge clk);
    check("pre_rst_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", int'(bus.ack), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_grant", int'(bus.grant_id), 0);
    check("mid_rst_result", int'({bus.aeqb, bus.agtb, bus.altb}), 0);
    @(negedge clk);
    check("mid_rst_noack", int'(bus.ack), 0);
    rst_n = 1'b1;
    last_m = NREQ - 1;
    serve(1'b0, 1'b0);
    check("post_rst_gt", int'(bus.agtb), 1);

    // Randomized traffic, operands sometimes changed mid-flight.
    for (int t = 0; t < 30; t++) begin
      rand_ops();
      req_v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      drive();
      while (req_v != '0) serve(1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
